writeback_ctrl: RTL and testbench

WRITEBACK_CTRL -- requirements
Module: writeback_ctrl

---
 rtl/rv32_pkg.sv | 29 ++
 rtl/wb_fifo2.sv | 65 ++++++
 rtl/writeback_ctrl.sv | 110 +++++++++++
 tb/tb_writeback_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared widths and types for the RV32 writeback path.
// Holds the register-file geometry and the MUL/DIV result-buffer depth.
package rv32_pkg;

    localparam int XLEN          = 32;
    localparam int REG_AW        = 5;
    localparam int NREGS         = 32;
    localparam int WB_FIFO_DEPTH = 2;
    localparam int WB_PTR_W      = 1;
    localparam int WB_CNT_W      = 2;

    typedef logic [XLEN-1:0]   word_t;
    typedef logic [REG_AW-1:0] reg_addr_t;

    typedef struct packed {
        reg_addr_t rd;
        word_t     data;
    } wb_entry_t;

    // x0 is hardwired, so it never appears in a register mask
    function automatic logic [NREGS-1:0] reg_mask(input reg_addr_t addr);
        logic [NREGS-1:0] mask;
        mask       = '0;
        mask[addr] = 1'b1;
        mask[0]    = 1'b0;
        return mask;
    endfunction

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry result buffer for MUL/DIV writebacks.
// Head is read combinationally from the register array; a push is visible only next cycle.
module wb_fifo2
    import rv32_pkg::*;
(
    input  logic      CLK,
    input  logic      RESET,
    input  logic      push,
    input  wb_entry_t push_entry,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output wb_entry_t head
);

    wb_entry_t               mem_reg [WB_FIFO_DEPTH];
    logic [WB_PTR_W-1:0]     wr_ptr_reg, wr_ptr_next;
    logic [WB_PTR_W-1:0]     rd_ptr_reg, rd_ptr_next;
    logic [WB_CNT_W-1:0]     count_reg, count_next;
    logic                    do_push;
    logic                    do_pop;

    assign full    = (count_reg == WB_CNT_W'(WB_FIFO_DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_reg[rd_ptr_reg];

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (do_push) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Data storage needs no reset: stale entries are unreachable once the count is cleared
    always_ff @(posedge CLK) begin
        if (!RESET && do_push) begin
            mem_reg[wr_ptr_reg] <= push_entry;
        end
    end

endmodule

// File: rtl/writeback_ctrl.sv
// Register-file writeback arbiter: single-cycle pipeline results win, buffered MUL/DIV
// results drain when the pipeline is idle; BUSY tracks registers awaiting MUL/DIV data.
module writeback_ctrl
    import rv32_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic              PIPE_VALID,
    input  logic [REG_AW-1:0] PIPE_RD,
    input  logic [XLEN-1:0]   PIPE_DATA,
    input  logic              MD_ISSUE,
    input  logic [REG_AW-1:0] MD_ISSUE_RD,
    input  logic              MD_VALID,
    input  logic [REG_AW-1:0] MD_RD,
    input  logic [XLEN-1:0]   MD_DATA,
    output logic              MD_READY,
    output logic              RF_WRITE,
    output logic [REG_AW-1:0] RF_ADDRW,
    output logic [XLEN-1:0]   RF_IN,
    output logic [NREGS-1:0]  BUSY,
    output logic              MD_OVF
);

    logic              fifo_full;
    logic              fifo_empty;
    wb_entry_t         fifo_head;
    wb_entry_t         md_entry;
    logic              md_push;
    logic              md_pop;

    logic              rf_write_reg, rf_write_next;
    logic [REG_AW-1:0] rf_addrw_reg, rf_addrw_next;
    logic [XLEN-1:0]   rf_in_reg, rf_in_next;
    logic [NREGS-1:0]  busy_reg, busy_next;
    logic [NREGS-1:0]  issue_mask;
    logic [NREGS-1:0]  retire_mask;
    logic              md_ovf_reg, md_ovf_next;

    assign MD_READY = !fifo_full;
    assign md_push  = MD_VALID && MD_READY;
    assign md_pop   = !PIPE_VALID && !fifo_empty;
    assign md_entry = '{rd: MD_RD, data: MD_DATA};

    wb_fifo2 u_fifo (
        .CLK        (CLK),
        .RESET      (RESET),
        .push       (md_push),
        .push_entry (md_entry),
        .pop        (md_pop),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head       (fifo_head)
    );

    // A selected rd=0 result is consumed but suppresses the write strobe
    always_comb begin
        rf_write_next = 1'b0;
        rf_addrw_next = rf_addrw_reg;
        rf_in_next    = rf_in_reg;
        if (PIPE_VALID) begin
            rf_write_next = (PIPE_RD != '0);
            rf_addrw_next = PIPE_RD;
            rf_in_next    = PIPE_DATA;
        end else if (md_pop) begin
            rf_write_next = (fifo_head.rd != '0);
            rf_addrw_next = fifo_head.rd;
            rf_in_next    = fifo_head.data;
        end
    end

    assign md_ovf_next = md_ovf_reg || (MD_VALID && !MD_READY);

    assign issue_mask  = MD_ISSUE ? reg_mask(MD_ISSUE_RD) : '0;
    assign retire_mask = md_pop ? reg_mask(fifo_head.rd) : '0;

    // Issue beats retire on the same register: the new op still owes a result
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                assign busy_next[gi] = 1'b0;
            end else begin : g_reg
                assign busy_next[gi] = issue_mask[gi] ||
                                       (busy_reg[gi] && !retire_mask[gi]);
            end
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rf_write_reg <= 1'b0;
            rf_addrw_reg <= '0;
            rf_in_reg    <= '0;
            busy_reg     <= '0;
            md_ovf_reg   <= 1'b0;
        end else begin
            rf_write_reg <= rf_write_next;
            rf_addrw_reg <= rf_addrw_next;
            rf_in_reg    <= rf_in_next;
            busy_reg     <= busy_next;
            md_ovf_reg   <= md_ovf_next;
        end
    end

    assign RF_WRITE = rf_write_reg;
    assign RF_ADDRW = rf_addrw_reg;
    assign RF_IN    = rf_in_reg;
    assign BUSY     = busy_reg;
    assign MD_OVF   = md_ovf_reg;

endmodule

// File: tb/tb_writeback_ctrl.sv
// Bench for writeback_ctrl: directed scenarios with literal expectations, then random
// traffic checked every cycle against a queue-based reference model.
module tb_writeback_ctrl;

    logic        CLK;
    logic        RESET;
    logic        PIPE_VALID;
    logic [4:0]  PIPE_RD;
    logic [31:0] PIPE_DATA;
    logic        MD_ISSUE;
    logic [4:0]  MD_ISSUE_RD;
    logic        MD_VALID;
    logic [4:0]  MD_RD;
    logic [31:0] MD_DATA;
    logic        MD_READY;
    logic        RF_WRITE;
    logic [4:0]  RF_ADDRW;
    logic [31:0] RF_IN;
    logic [31:0] BUSY;
    logic        MD_OVF;

    writeback_ctrl dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .PIPE_VALID  (PIPE_VALID),
        .PIPE_RD     (PIPE_RD),
        .PIPE_DATA   (PIPE_DATA),
        .MD_ISSUE    (MD_ISSUE),
        .MD_ISSUE_RD (MD_ISSUE_RD),
        .MD_VALID    (MD_VALID),
        .MD_RD       (MD_RD),
        .MD_DATA     (MD_DATA),
        .MD_READY    (MD_READY),
        .RF_WRITE    (RF_WRITE),
        .RF_ADDRW    (RF_ADDRW),
        .RF_IN       (RF_IN),
        .BUSY        (BUSY),
        .MD_OVF      (MD_OVF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_mis = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: result buffer as a queue, scoreboard as a bit array
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_busy;
    logic        m_ovf;
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    bit          m_valid = 0;

    // At each falling edge: check outputs against the model, then advance the model
    // with the inputs that the next rising edge will sample.
    initial begin
        forever begin
            @(negedge CLK);
            if (m_valid) begin
                chk("rf_write", {31'b0, RF_WRITE}, {31'b0, m_we});
                chk("rf_addrw", {27'b0, RF_ADDRW}, {27'b0, m_addr});
                chk("rf_in",    RF_IN, m_data);
                chk("busy",     BUSY, m_busy);
                chk("md_ovf",   {31'b0, MD_OVF}, {31'b0, m_ovf});
                chk("md_ready", {31'b0, MD_READY}, {31'b0, mq.size() < 2});
            end
            if (RESET) begin
                mq.delete();
                m_busy  = '0;
                m_ovf   = 1'b0;
                m_we    = 1'b0;
                m_addr  = '0;
                m_data  = '0;
                m_valid = 1;
            end else if (m_valid) begin
                bit   room;
                bit   take;
                ent_t hd;
                room = (mq.size() < 2);
                take = !PIPE_VALID && (mq.size() > 0);
                if (take) hd = mq[0];
                if (PIPE_VALID) begin
                    m_we   = (PIPE_RD != 0);
                    m_addr = PIPE_RD;
                    m_data = PIPE_DATA;
                end else if (take) begin
                    m_we   = (hd.rd != 0);
                    m_addr = hd.rd;
                    m_data = hd.data;
                end else begin
                    m_we = 1'b0;
                end
                if (take) begin
                    void'(mq.pop_front());
                    m_busy[hd.rd] = 1'b0;
                end
                if (MD_ISSUE) m_busy[MD_ISSUE_RD] = 1'b1;
                m_busy[0] = 1'b0;
                if (MD_VALID) begin
                    if (room) mq.push_back('{rd: MD_RD, data: MD_DATA});
                    else      m_ovf = 1'b1;
                end
            end
        end
    end

    task automatic step(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                        input logic iss, input logic [4:0] ird,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] md);
        PIPE_VALID  = pv;
        PIPE_RD     = prd;
        PIPE_DATA   = pd;
        MD_ISSUE    = iss;
        MD_ISSUE_RD = ird;
        MD_VALID    = mv;
        MD_RD       = mrd;
        MD_DATA     = md;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        idle();
        RESET = 1'b0;
    endtask

    initial begin
        RESET = 1'b1;
        PIPE_VALID = 0; PIPE_RD = 0; PIPE_DATA = 0;
        MD_ISSUE = 0; MD_ISSUE_RD = 0; MD_VALID = 0; MD_RD = 0; MD_DATA = 0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_we",    {31'b0, RF_WRITE}, 32'd0);
        chk("rst_busy",  BUSY, 32'd0);
        chk("rst_ready", {31'b0, MD_READY}, 32'd1);
        RESET = 1'b0;

        // Pipeline result lands one cycle later
        step(1, 5, 32'h12345678, 0, 0, 0, 0, 0);
        chk("pipe_we",   {31'b0, RF_WRITE}, 32'd1);
        chk("pipe_addr", {27'b0, RF_ADDRW}, 32'd5);
        chk("pipe_in",   RF_IN, 32'h12345678);
        idle();
        chk("pipe_hold_we",   {31'b0, RF_WRITE}, 32'd0);
        chk("pipe_hold_addr", {27'b0, RF_ADDRW}, 32'd5);

        // MD issue rd7, push, writeback at push+2
        step(0, 0, 0, 1, 7, 0, 0, 0);
        chk("md7_busy_set", BUSY, 32'h0000_0080);
        step(0, 0, 0, 0, 0, 1, 7, 32'hA5A5A5A5);
        chk("md7_nobypass_we", {31'b0, RF_WRITE}, 32'd0);
        chk("md7_busy_held",   BUSY, 32'h0000_0080);
        idle();
        chk("md7_we",   {31'b0, RF_WRITE}, 32'd1);
        chk("md7_addr", {27'b0, RF_ADDRW}, 32'd7);
        chk("md7_in",   RF_IN, 32'hA5A5A5A5);
        chk("md7_busy_clr", BUSY, 32'd0);

        // Pipeline holds priority while the buffer fills and overflows
        step(1, 10, 32'h10, 0, 0, 1, 3, 32'h1);
        chk("ovf_ready1", {31'b0, MD_READY}, 32'd1);
        step(1, 11, 32'h11, 0, 0, 1, 4, 32'h2);
        chk("ovf_ready0", {31'b0, MD_READY}, 32'd0);
        step(1, 12, 32'h12, 0, 0, 1, 6, 32'h3);
        chk("ovf_flag", {31'b0, MD_OVF}, 32'd1);
        step(1, 13, 32'h13, 0, 0, 0, 0, 0);
        chk("ovf_pipe_addr", {27'b0, RF_ADDRW}, 32'd13);
        idle();
        chk("drain1_addr", {27'b0, RF_ADDRW}, 32'd3);
        chk("drain1_in",   RF_IN, 32'h1);
        idle();
        chk("drain2_addr", {27'b0, RF_ADDRW}, 32'd4);
        chk("drain2_in",   RF_IN, 32'h2);
        idle();
        chk("drain_done_we", {31'b0, RF_WRITE}, 32'd0);
        chk("drain_ready",   {31'b0, MD_READY}, 32'd1);
        chk("ovf_sticky",    {31'b0, MD_OVF}, 32'd1);

        // rd=0 results are consumed without a write strobe
        do_reset();
        step(1, 0, 32'hDEAD0000, 0, 0, 1, 0, 32'hBEEF);
        chk("x0_pipe_we", {31'b0, RF_WRITE}, 32'd0);
        step(1, 0, 32'hDEAD0001, 0, 0, 1, 0, 32'hBEF0);
        chk("x0_full", {31'b0, MD_READY}, 32'd0);
        idle();
        chk("x0_md_we",   {31'b0, RF_WRITE}, 32'd0);
        chk("x0_dec",     {31'b0, MD_READY}, 32'd1);
        chk("x0_busy",    BUSY, 32'd0);

        // Issue and retire of rd9 in the same cycle keeps BUSY[9]
        step(0, 0, 0, 1, 9, 0, 0, 0);
        idle();
        step(0, 0, 0, 0, 0, 1, 9, 32'h99);
        step(0, 0, 0, 1, 9, 0, 0, 0);
        chk("rd9_we",   {31'b0, RF_WRITE}, 32'd1);
        chk("rd9_addr", {27'b0, RF_ADDRW}, 32'd9);
        chk("rd9_busy", BUSY, 32'h0000_0200);

        // Reset with a full buffer discards everything
        do_reset();
        step(1, 1, 32'h1, 1, 7, 1, 7, 32'h77);
        step(1, 2, 32'h2, 1, 9, 1, 9, 32'h99);
        chk("pre_rst_busy",  BUSY, 32'h0000_0280);
        chk("pre_rst_ready", {31'b0, MD_READY}, 32'd0);
        RESET = 1'b1;
        step(1, 3, 32'h3, 1, 4, 1, 4, 32'h44);
        RESET = 1'b0;
        chk("rst_mid_we",    {31'b0, RF_WRITE}, 32'd0);
        chk("rst_mid_busy",  BUSY, 32'd0);
        chk("rst_mid_ready", {31'b0, MD_READY}, 32'd1);
        idle();
        chk("rst_discard_we", {31'b0, RF_WRITE}, 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            RESET = ($urandom_range(0, 199) == 0);
            step($urandom_range(0, 99) < 45, 5'($urandom_range(0, 31)), $urandom,
                 $urandom_range(0, 99) < 30, 5'($urandom_range(0, 31)),
                 $urandom_range(0, 99) < 40, 5'($urandom_range(0, 31)), $urandom);
        end
        RESET = 1'b0;
        repeat (4) idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
